// File: rtl/uart_fmt_pkg.sv
// Shared definitions for the ASCII formatters that feed the UART transmitter.
package uart_fmt_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_P0      = 3'd1,
        S_P1      = 3'd2,
        S_DIG     = 3'd3,
        S_CR      = 3'd4,
        S_LF      = 3'd5,
        S_GAP_END = 3'd6
    } state_t;

    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_X  = 8'h78;
    localparam logic [7:0] ASC_A  = 8'h41;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational nibble-to-ASCII converter; digits above 9 map to uppercase A-F.
module hex_nibble_to_ascii
    import uart_fmt_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_ascii_c
);

    always_comb begin
        if (i_nibble < 4'd10) begin
            o_ascii_c = ASC_0 + 8'(i_nibble);
        end else begin
            o_ascii_c = ASC_A + 8'(i_nibble) - 8'd10;
        end
    end

endmodule

// File: rtl/uart_hex_formatter.sv
// Prints a captured binary word as ASCII hex, one byte per transmitter enqueue pulse,
// optionally wrapped as "0x....\r\n".
module uart_hex_formatter
    import uart_fmt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          PREFIX_EN  = 1'b1,
    parameter bit          NEWLINE_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  value_valid,
    input  logic [DATA_WIDTH-1:0] value,
    output logic                  in_ready,
    input  logic                  tx_fifo_ready,
    output logic                  tx_start,
    output logic [7:0]            tx_data
);

    localparam int unsigned N_DIGITS = DATA_WIDTH / 4;
    localparam int unsigned CNT_W    = $clog2(N_DIGITS) + 1;

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_sh;
    logic [DATA_WIDTH-1:0] w_sh_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    logic                  r_tx_start;
    logic [7:0]            r_tx_data;
    logic                  r_in_ready;
    logic                  w_emit_ok;
    logic                  w_emit;
    logic [7:0]            w_byte;
    logic [7:0]            w_digit;

    hex_nibble_to_ascii u_nibble (
        .i_nibble  (r_sh[DATA_WIDTH-1 -: 4]),
        .o_ascii_c (w_digit)
    );

    // The previous pulse doubles as the pacing flag: the transmitter's ready lags by a cycle.
    assign w_emit_ok = tx_fifo_ready && !r_tx_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sh_next    = r_sh;
        w_cnt_next   = r_cnt;
        w_emit       = 1'b0;
        w_byte       = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (value_valid && r_in_ready) begin
                    w_sh_next  = value;
                    w_cnt_next = CNT_W'(N_DIGITS);
                    if (PREFIX_EN) w_state_next = S_P0;
                    else           w_state_next = S_DIG;
                end
            end
            S_P0: begin
                w_byte = ASC_0;
                if (w_emit_ok) begin
                    w_emit       = 1'b1;
                    w_state_next = S_P1;
                end
            end
            S_P1: begin
                w_byte = ASC_X;
                if (w_emit_ok) begin
                    w_emit       = 1'b1;
                    w_state_next = S_DIG;
                end
            end
            S_DIG: begin
                w_byte = w_digit;
                if (w_emit_ok) begin
                    w_emit     = 1'b1;
                    w_sh_next  = r_sh << 4;
                    w_cnt_next = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        if (NEWLINE_EN) w_state_next = S_CR;
                        else            w_state_next = S_GAP_END;
                    end
                end
            end
            S_CR: begin
                w_byte = ASC_CR;
                if (w_emit_ok) begin
                    w_emit       = 1'b1;
                    w_state_next = S_LF;
                end
            end
            S_LF: begin
                w_byte = ASC_LF;
                if (w_emit_ok) begin
                    w_emit       = 1'b1;
                    w_state_next = S_GAP_END;
                end
            end
            S_GAP_END: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; tx_data only moves when a byte is actually enqueued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh       <= '0;
            r_cnt      <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_in_ready <= 1'b0;
        end else begin
            r_sh       <= w_sh_next;
            r_cnt      <= w_cnt_next;
            r_tx_start <= w_emit;
            if (w_emit) r_tx_data <= w_byte;
            r_in_ready <= (w_state_next == S_IDLE);
        end
    end

    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign in_ready = r_in_ready;

endmodule
